uart_cmd_rcvr: RTL and testbench

//  Receive end of the 8N1 UART link that carries rider commands (e.g. 'G', 'S') from the BLE module to the Segway.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rx_synch.sv | 36 +++
 rtl/uart_cmd_rcvr.sv | 124 ++++++++++++
 tb/tb_uart_cmd_rcvr.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   rx_state_t : receiver FSM state encoding
//   BAUD_DIV   : clk cycles per bit (50 MHz / 19200 baud)
//   HALF_DIV   : clk cycles from start-bit edge to start-bit mid-sample
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int BAUD_DIV = 2604;
   localparam int HALF_DIV = BAUD_DIV / 2;

endpackage

// File: rtl/rx_synch.sv
// Two-flop synchronizer for an asynchronous, idle-high input, with a
// registered falling-edge pulse. Flops preset to 1 so that reset looks like an
// idle line and never produces a spurious edge.
//   clk      in  1  system clock
//   rst_n    in  1  asynchronous active-low reset
//   async_in in  1  asynchronous input pin
//   sync_out out 1  synchronized level (second flop)
//   fall     out 1  one-cycle pulse, registered, after sync_out goes 1->0
module rx_synch (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic fall
);

   logic ff1, ff2, ff3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1  <= 1'b1;
         ff2  <= 1'b1;
         ff3  <= 1'b1;
         fall <= 1'b0;
      end else begin
         ff1  <= async_in;
         ff2  <= ff1;
         ff3  <= ff2;
         // ff3 holds the previous synchronized level
         fall <= ff3 & ~ff2;
      end
   end

   assign sync_out = ff2;

endmodule

// File: rtl/uart_cmd_rcvr.sv
// 8N1 UART receiver for rider commands arriving from the BLE module.
// Recovers bytes from RX, flags framing and overrun errors, and presents each
// byte through a rdy/clr_rdy handshake.
// Handshake: rdy rises when a byte with a good stop bit lands in rx_data and
// stays high until clr_rdy is seen on a clock edge. clr_rdy also clears ovr and
// frm_err. A good byte completing in the same cycle as clr_rdy wins: rdy stays
// 1, ovr goes 0, rx_data takes the new byte.
//   clk      in  1  system clock, 50 MHz
//   rst_n    in  1  asynchronous active-low reset
//   RX       in  1  serial input, idle high, asynchronous to clk
//   clr_rdy  in  1  consumer acknowledge
//   rx_data  out 8  last good received byte (LSB first on the wire)
//   rdy      out 1  byte valid, held until clr_rdy
//   frm_err  out 1  sticky: stop bit sampled low
//   ovr      out 1  sticky: good byte completed while rdy was still set
//   state    out 2  current receiver FSM state (debug observation)
module uart_cmd_rcvr
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = uart_pkg::BAUD_DIV,
   parameter int HALF_DIV = uart_pkg::HALF_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       ovr,
   output rx_state_t  state
);

   localparam logic [11:0] BAUD_LOAD = 12'(BAUD_DIV - 1);
   localparam logic [11:0] HALF_LOAD = 12'(HALF_DIV - 1);

   logic        rx_sync;
   logic        rx_fall;
   logic [11:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift_reg;

   rx_synch u_rx_synch (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (RX),
      .sync_out (rx_sync),
      .fall     (rx_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rdy       <= 1'b0;
         frm_err   <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         // Acknowledge first; a frame completing below overrides it.
         if (clr_rdy) begin
            rdy     <= 1'b0;
            ovr     <= 1'b0;
            frm_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rx_fall) begin
                  baud_cnt <= HALF_LOAD;
                  state    <= START;
               end
            end

            START: begin
               if (baud_cnt == 12'd0) begin
                  if (rx_sync) begin
                     // Line back high at mid start bit: glitch, drop it.
                     state <= IDLE;
                  end else begin
                     baud_cnt <= BAUD_LOAD;
                     bit_cnt  <= 4'd0;
                     state    <= DATA;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 12'd1;
               end
            end

            DATA: begin
               if (baud_cnt == 12'd0) begin
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  baud_cnt  <= BAUD_LOAD;
                  bit_cnt   <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 12'd1;
               end
            end

            STOP: begin
               if (baud_cnt == 12'd0) begin
                  if (rx_sync) begin
                     rx_data <= shift_reg;
                     rdy     <= 1'b1;
                     frm_err <= 1'b0;
                     if (rdy && !clr_rdy) ovr <= 1'b1;
                  end else begin
                     frm_err <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt - 12'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_rcvr.sv
// Bench for uart_cmd_rcvr with a shortened bit period.
module tb_uart_cmd_rcvr;
   import uart_pkg::*;

   localparam int BD = 16;
   localparam int HD = 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy, frm_err, ovr;
   rx_state_t  state;

   always #5 clk = ~clk;

   uart_cmd_rcvr #(.BAUD_DIV(BD), .HALF_DIV(HD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .ovr     (ovr),
      .state   (state)
   );

   int checks = 0;
   int errors = 0;

   // expected {rx_data, rdy, frm_err, ovr} at each return to IDLE from START/STOP
   logic [10:0] exp_q[$];
   logic [10:0] exp_v;
   rx_state_t   prev_state = IDLE;

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && state == IDLE && (prev_state == START || prev_state == STOP)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got data=%h rdy=%b frm=%b ovr=%b, required no event",
                     rx_data, rdy, frm_err, ovr);
         end else begin
            exp_v = exp_q.pop_front();
            if ({rx_data, rdy, frm_err, ovr} !== exp_v) begin
               errors++;
               $display("FAIL frame_result: got data=%h rdy=%b frm=%b ovr=%b, required data=%h rdy=%b frm=%b ovr=%b",
                        rx_data, rdy, frm_err, ovr, exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
         end
      end
      prev_state = state;
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic drive_bit(input logic b, input int cycles);
      RX = b;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0, BD);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BD);
      drive_bit(stop_bit, BD);
      drive_bit(1'b1, BD);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 4 * BD && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d pending events, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_rdy = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_data", 32'(rx_data), 32'h00);
      check("reset_rdy", 32'(rdy), 32'h0);
      check("reset_frm", 32'(frm_err), 32'h0);
      check("reset_ovr", 32'(ovr), 32'h0);
      check("reset_state", 32'(state), 32'(IDLE));
      drive_bit(1'b1, 2 * BD);

      // two good bytes, each acknowledged
      exp_q.push_back({8'hA5, 1'b1, 1'b0, 1'b0});
      send_frame(8'hA5, 1'b1);
      wait_drain("a5");
      pulse_clr();
      check("clr_a5_rdy", 32'(rdy), 32'h0);
      exp_q.push_back({8'h47, 1'b1, 1'b0, 1'b0});
      send_frame(8'h47, 1'b1);
      wait_drain("g47");
      pulse_clr();
      check("clr_47_rdy", 32'(rdy), 32'h0);

      // short low glitch: START aborts, nothing changes
      exp_q.push_back({8'h47, 1'b0, 1'b0, 1'b0});
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 3 * BD);
      wait_drain("glitch");

      // bad stop bit
      exp_q.push_back({8'h47, 1'b0, 1'b1, 1'b0});
      send_frame(8'h3C, 1'b0);
      wait_drain("frm");
      pulse_clr();
      check("clr_frm_err", 32'(frm_err), 32'h0);
      check("clr_frm_data", 32'(rx_data), 32'h47);

      // overrun
      exp_q.push_back({8'h11, 1'b1, 1'b0, 1'b0});
      send_frame(8'h11, 1'b1);
      exp_q.push_back({8'h22, 1'b1, 1'b0, 1'b1});
      send_frame(8'h22, 1'b1);
      wait_drain("ovr");
      pulse_clr();
      check("clr_ovr_rdy", 32'(rdy), 32'h0);
      check("clr_ovr_ovr", 32'(ovr), 32'h0);

      // clr_rdy on the exact stop-sample cycle while rdy=1
      exp_q.push_back({8'h99, 1'b1, 1'b0, 1'b0});
      send_frame(8'h99, 1'b1);
      wait_drain("pre5a");
      exp_q.push_back({8'h5A, 1'b1, 1'b0, 1'b0});
      fork
         send_frame(8'h5A, 1'b1);
         begin
            for (int i = 0; i < 20 * BD && state != STOP; i++) @(negedge clk);
            check("reach_stop", 32'(state), 32'(STOP));
            repeat (BD - 1) @(posedge clk);
            #1;
            clr_rdy = 1'b1;
            @(posedge clk);
            #1;
            clr_rdy = 1'b0;
         end
      join
      wait_drain("clr_race");

      // async reset in the middle of bit 4, then a clean byte
      drive_bit(1'b0, BD);
      drive_bit(1'b1, BD);
      drive_bit(1'b1, BD);
      drive_bit(1'b0, BD);
      drive_bit(1'b0, BD);
      drive_bit(1'b0, BD / 2);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_data", 32'(rx_data), 32'h00);
      check("midrst_rdy", 32'(rdy), 32'h0);
      check("midrst_frm", 32'(frm_err), 32'h0);
      check("midrst_ovr", 32'(ovr), 32'h0);
      check("midrst_state", 32'(state), 32'(IDLE));
      RX = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_bit(1'b1, 2 * BD);
      exp_q.push_back({8'hC3, 1'b1, 1'b0, 1'b0});
      send_frame(8'hC3, 1'b1);
      wait_drain("c3");

      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of stimulus, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
